// File: rtl/or1200_sha3_pad.sv
// SHA3 message padder: packs 32-bit message words into RATE_WORDS-word rate blocks,
// applies 0x06 ... 0x80 domain padding on the tail word and hands blocks downstream.
module or1200_sha3_pad #(
    parameter int RATE_WORDS = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_head,
    input  logic                      in_tail,
    input  logic [31:0]               in_data,
    input  logic [1:0]                in_nbytes,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic [32*RATE_WORDS-1:0]  blk_data,
    output logic                      blk_first,
    output logic                      blk_last,
    output logic                      proto_err
);

    localparam int BW  = 32 * RATE_WORDS;
    localparam int WCW = $clog2(RATE_WORDS + 1);
    localparam int BIW = $clog2(BW);

    // Handshakes: a word moves when in_valid && in_ready; a block moves when
    // blk_valid && blk_ready. Offered data must stay stable until it moves.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [BW-1:0]    buf_q, buf_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             perr_q, perr_d;

    logic             do_start, do_store, do_tail;
    logic [WCW-1:0]   w;
    logic [BIW-1:0]   base;
    logic [31:0]      keep, tw;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        buf_d    = buf_q;
        first_d  = first_q;
        last_d   = last_q;
        perr_d   = perr_q;
        do_start = 1'b0;
        do_store = 1'b0;
        do_tail  = 1'b0;
        w        = wcnt_q;
        base     = '0;
        keep     = '0;
        tw       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_head) do_start = 1'b1;
                    else         perr_d   = 1'b1;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    if (in_head) begin
                        do_start = 1'b1;
                        perr_d   = 1'b1;
                    end else if (in_tail) begin
                        do_tail = 1'b1;
                    end else begin
                        do_store = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (blk_ready) begin
                    buf_d  = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                        wcnt_d  = '0;
                        first_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A head word with in_tail set is a head followed by a tail reusing the same word.
        if (do_start) begin
            buf_d            = '0;
            buf_d[BW-1 -: 32] = in_data;
            w                = WCW'(1);
            first_d          = 1'b1;
            last_d           = 1'b0;
            state_d          = S_FILL;
            do_tail          = in_tail;
        end

        if (do_store) begin
            base              = BIW'(BW - 1 - 32 * int'(w));
            buf_d[base -: 32] = in_data;
            w                 = w + WCW'(1);
        end

        if (do_tail) begin
            unique case (in_nbytes)
                2'd0:    keep = 32'h0000_0000;
                2'd1:    keep = 32'hFF00_0000;
                2'd2:    keep = 32'hFFFF_0000;
                default: keep = 32'hFFFF_FF00;
            endcase
            // The 0x06 byte always lands inside the tail word since in_nbytes <= 3.
            tw                = (in_data & keep) | (32'h0600_0000 >> {in_nbytes, 3'b000});
            base              = BIW'(BW - 1 - 32 * int'(w));
            buf_d[base -: 32] = tw;
            buf_d[7:0]        = buf_d[7:0] | 8'h80;
            last_d            = 1'b1;
            state_d           = S_OUT;
        end else if ((do_start || do_store) && (w == WCW'(RATE_WORDS))) begin
            last_d  = 1'b0;
            state_d = S_OUT;
        end

        if (do_start || do_store || do_tail) wcnt_d = w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            buf_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            buf_q   <= buf_d;
            first_q <= first_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
        end
    end

    assign in_ready  = !rst && (state_q != S_OUT);
    assign blk_valid = (state_q == S_OUT);
    assign blk_data  = buf_q;
    assign blk_first = first_q && blk_valid;
    assign blk_last  = last_q && blk_valid;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_or1200_sha3_pad.sv
// Bench for or1200_sha3_pad: directed vector table, stall/reset/protocol sequences and
// random messages scored against a queue-based SHA3 padding model.
module tb_or1200_sha3_pad;

    localparam int RW = 18;
    localparam int BW = 32 * RW;
    localparam int BB = 4 * RW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_head;
    logic          in_tail;
    logic [31:0]   in_data;
    logic [1:0]    in_nbytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [BW-1:0] blk_data;
    logic          blk_first;
    logic          blk_last;
    logic          proto_err;

    or1200_sha3_pad #(.RATE_WORDS(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_head   (in_head),
        .in_tail   (in_tail),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .proto_err (proto_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // downstream ready: 0 = hold low, 1 = hold high, 2 = random
    int rdy_mode;
    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       blk_ready = 1'b0;
                1:       blk_ready = 1'b1;
                default: blk_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // scoreboard state
    logic [BW-1:0] exp_q[$];
    logic          expf_q[$];
    logic          expl_q[$];
    logic [7:0]    msg_q[$];
    int            checks;
    int            failures;
    int            blk_cnt;
    logic [BW-1:0] last_blk;

    logic [351:0] txt;

    typedef struct {
        int          nbody;
        logic [1:0]  nb;
        bit          use_txt;
        logic [31:0] tail_d;
        int          exp_blocks;
        int          exp_pos;
        logic [7:0]  exp_val;
        logic [7:0]  exp_b71;
    } vec_t;
    vec_t vecs[5];

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [BW-1:0] v, input int j);
        return 8'(v >> (BW - 8 - 8 * j));
    endfunction

    // reference model: append 0x06, zero-fill to a whole number of blocks, OR 0x80 into the last byte
    task automatic push_expected();
        logic [7:0]    p[$];
        logic [BW-1:0] blk;
        int            nblk;
        p = msg_q;
        p.push_back(8'h06);
        while (p.size() % BB != 0) p.push_back(8'h00);
        p[p.size() - 1] = p[p.size() - 1] | 8'h80;
        nblk = p.size() / BB;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < BB; j++) blk = {blk[BW-9:0], p[b * BB + j]};
            exp_q.push_back(blk);
            expf_q.push_back(b == 0);
            expl_q.push_back(b == nblk - 1);
        end
    endtask

    // driver: called and returns just after a rising edge
    task automatic send_word(input logic h, input logic t, input logic [31:0] d, input logic [1:0] nb);
        int cyc;
        in_valid  = 1'b1;
        in_head   = h;
        in_tail   = t;
        in_data   = d;
        in_nbytes = nb;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk_i("word_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_head  = 1'b0;
        in_tail  = 1'b0;
    endtask

    task automatic send_msg(input int nbody, input logic [1:0] nb, input bit ht, input bit with_tail,
                            input bit exp_blk, input bit use_txt, input logic [31:0] tail_d,
                            input int gap_max);
        logic [31:0] w[$];
        int          nw;
        for (int i = 0; i <= nbody; i++)
            w.push_back(use_txt ? 32'(txt >> (320 - 32 * i)) : $urandom);
        if (with_tail && !ht) w.push_back(tail_d);
        nw = w.size();
        msg_q = {};
        for (int i = 0; i < nw; i++) begin
            if (!(with_tail && !ht && i == nw - 1))
                for (int k = 0; k < 4; k++) msg_q.push_back(8'(w[i] >> (24 - 8 * k)));
        end
        if (with_tail)
            for (int k = 0; k < int'(nb); k++) msg_q.push_back(8'(w[nw - 1] >> (24 - 8 * k)));
        if (exp_blk) push_expected();
        for (int i = 0; i < nw; i++) begin
            send_word(i == 0, with_tail && (i == nw - 1), w[i], nb);
            for (int g = 0; g < int'($urandom_range(0, gap_max)); g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        chk_i("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [BW-1:0] hold;
        int            c0;
        int            cyc;

        checks    = 0;
        failures  = 0;
        blk_cnt   = 0;
        last_blk  = '0;
        rdy_mode  = 1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_head   = 1'b0;
        in_tail   = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        txt       = "The quick brown fox jumps over the lazy dog.";

        vecs[0] = '{10, 2'd0, 1'b1, 32'h0000_0000,  1, 44, 8'h06, 8'h80};
        vecs[1] = '{16, 2'd3, 1'b0, 32'h6162_6300,  1, 70, 8'h63, 8'h86};
        vecs[2] = '{17, 2'd0, 1'b0, 32'h1234_5678,  2,  0, 8'h06, 8'h80};
        vecs[3] = '{ 0, 2'd2, 1'b0, 32'hA1B2_C3D4,  1,  6, 8'h06, 8'h80};
        vecs[4] = '{16, 2'd0, 1'b0, 32'hDEAD_BEEF,  1, 68, 8'h06, 8'h80};

        // block monitor
        fork
            begin
                logic [BW-1:0] e;
                forever begin
                    @(negedge clk);
                    if (blk_valid && blk_ready) begin
                        blk_cnt++;
                        last_blk = blk_data;
                        if (exp_q.size() == 0) begin
                            chk_i("unexpected_block", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk_w("blk_data", blk_data, e);
                            chk_i("blk_first", int'(blk_first), int'(expf_q.pop_front()));
                            chk_i("blk_last", int'(blk_last), int'(expl_q.pop_front()));
                        end
                    end
                end
            end
        join_none

        // reset state, forced asynchronously
        #2 rst = 1'b1;
        #1;
        chk_i("rst_in_ready", int'(in_ready), 0);
        chk_i("rst_blk_valid", int'(blk_valid), 0);
        chk_w("rst_blk_data", blk_data, '0);
        chk_i("rst_blk_first", int'(blk_first), 0);
        chk_i("rst_blk_last", int'(blk_last), 0);
        chk_i("rst_proto_err", int'(proto_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_i("post_rst_in_ready", int'(in_ready), 1);

        // directed vector table
        for (int v = 0; v < 5; v++) begin
            c0 = blk_cnt;
            send_msg(vecs[v].nbody, vecs[v].nb, 1'b0, 1'b1, 1'b1, vecs[v].use_txt, vecs[v].tail_d, 0);
            wait_drain();
            chk_i("vec_blocks", blk_cnt - c0, vecs[v].exp_blocks);
            chk_i("vec_pad_byte", int'(byte_at(last_blk, vecs[v].exp_pos)), int'(vecs[v].exp_val));
            chk_i("vec_byte71", int'(byte_at(last_blk, BB - 1)), int'(vecs[v].exp_b71));
        end

        // stall: block held while blk_ready=0, offered words refused
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_msg(0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        cyc = 0;
        while (!blk_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_i("stall_valid", int'(blk_valid), 1);
        hold      = blk_data;
        in_valid  = 1'b1;
        in_head   = 1'b1;
        in_data   = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_w("stall_data_stable", blk_data, hold);
            chk_i("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_head  = 1'b0;
        rdy_mode = 1;
        wait_drain();

        // random messages with random gaps and random backpressure
        rdy_mode = 2;
        for (int m = 0; m < 25; m++) begin
            int   nbody;
            bit   ht;
            nbody = $urandom_range(0, 40);
            ht    = (nbody == 0) && ($urandom_range(0, 1) == 1);
            send_msg(nbody, 2'($urandom_range(0, 3)), ht, 1'b1, 1'b1, 1'b0, $urandom, 2);
        end
        rdy_mode = 1;
        wait_drain();
        chk_i("rand_no_proto_err", int'(proto_err), 0);

        // protocol errors: body word in IDLE, then a head during FILL
        send_word(1'b0, 1'b0, $urandom, 2'd0);
        chk_i("perr_idle_body", int'(proto_err), 1);
        c0 = blk_cnt;
        send_msg(3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        send_msg(2, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, $urandom, 0);
        wait_drain();
        chk_i("perr_one_block", blk_cnt - c0, 1);
        chk_i("perr_sticky", int'(proto_err), 1);

        // reset in the middle of a message
        c0 = blk_cnt;
        send_msg(5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        #3 rst = 1'b1;
        #1;
        chk_w("midrst_blk_data", blk_data, '0);
        chk_i("midrst_proto_err", int'(proto_err), 0);
        chk_i("midrst_in_ready", int'(in_ready), 0);
        chk_i("midrst_blk_valid", int'(blk_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send_msg(0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, $urandom, 0);
        chk_i("latency_valid", int'(blk_valid), 1);
        @(posedge clk);
        #1;
        chk_i("one_cycle_out", int'(blk_valid), 0);
        wait_drain();
        chk_i("midrst_blocks", blk_cnt - c0, 1);

        chk_i("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or1200_sha3_pad.md
OR1200_SHA3_PAD -- requirements
Module: or1200_sha3_pad

Interface
REQ-001 SHALL have parameter RATE_WORDS, default 18, giving the number of 32-bit words per rate block (576 bits, SHA3-512).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  message word offered.
REQ-005 SHALL have port in_ready  output  1  word accepted when in_valid && in_ready.
REQ-006 SHALL have port in_head  input  1  the word is the first of a message and carries 4 data bytes.
REQ-007 SHALL have port in_tail  input  1  the word is the last of a message and carries in_nbytes data bytes.
REQ-008 SHALL have port in_data  input  32  message bytes, first byte in [31:24].
REQ-009 SHALL have port in_nbytes  input  2  valid bytes on a tail word (0-3), MSB-justified; ignored on non-tail words.
REQ-010 SHALL have port blk_valid  output  1  padded rate block available.
REQ-011 SHALL have port blk_ready  input  1  downstream permutation core takes the block when blk_valid && blk_ready.
REQ-012 SHALL have port blk_data  output  32*RATE_WORDS  block; byte j occupies bits [32*RATE_WORDS-1-8j -: 8].
REQ-013 SHALL have port blk_first  output  1  the block is the first of its message (core clears state).
REQ-014 SHALL have port blk_last  output  1  the block is the final, padded block of its message.
REQ-015 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL implement states IDLE, FILL and OUT.
REQ-017 in_ready SHALL be 1 in IDLE and FILL and 0 in OUT.
REQ-018 IDLE, accepted head: clear buffer, store word at index 0, set wcnt=1, set first=1, go to FILL.
REQ-019 IDLE, accepted head together with in_tail: treat as head followed by a tail word with the same data and in_nbytes.
REQ-020 IDLE, accepted non-head word: drop it, set proto_err, stay in IDLE.
REQ-021 FILL, accepted non-head, non-tail word: store at index wcnt, then wcnt+1.
REQ-022 FILL, when wcnt reaches RATE_WORDS: go to OUT with blk_last=0.
REQ-023 FILL, accepted tail word: store in_nbytes bytes at byte n=4*wcnt, then set byte n to 0x06.
REQ-024 Tail padding (cont.): OR 0x80 into byte 4*RATE_WORDS-1, giving 0x86 when n = 4*RATE_WORDS-1; set all other unwritten bytes to 0; go to OUT with blk_last=1.
REQ-025 FILL, accepted head: abort the current message, set proto_err, restart as in REQ-018.
REQ-026 OUT: blk_valid=1, and blk_data/blk_first/blk_last SHALL stay stable until blk_ready.
REQ-027 OUT, on handshake when blk_last=1: go to IDLE and clear the buffer.
REQ-028 OUT, on handshake when blk_last=0: go to FILL, clear the buffer, set wcnt=0, set first=0.
REQ-029 A tail arriving with wcnt=0 after a full non-last block SHALL yield a block with byte0=0x06, byte(4*RATE_WORDS-1)=0x80 and all other bytes 0.
REQ-030 Latency: blk_valid SHALL rise the cycle after the word that fills the block, or after the tail word, is accepted.
REQ-031 Throughput: with blk_ready held at 1, OUT SHALL last exactly one cycle.
REQ-032 in_valid=0 SHALL never change state.
REQ-033 blk_first SHALL be 1 only on the first block after a head.

Reset
REQ-034 While rst=1 the block SHALL immediately force: state=IDLE, wcnt=0, buffer=0, blk_valid=0, blk_data=0, blk_first=0, blk_last=0, proto_err=0, in_ready=0.
REQ-035 After rst falls, in_ready SHALL be 1 from the first clock edge.
REQ-036 Reset mid-message SHALL discard the partial block, and no block SHALL be emitted for it.

Verification
REQ-037 head "The ", 10 body words "quic".."dog.", tail nbytes=0 -> one block: bytes 0-43 = text, byte44=0x06, byte71=0x80, rest 0, first=last=1.
REQ-038 head + 16 body words, tail "abc\0" with nbytes=3 -> bytes 68-70="abc", byte71=0x86, last=1.
REQ-039 head + 17 body words, tail nbytes=0 -> two blocks: the first is unpadded (first=1, last=0); the second has byte0=0x06, byte71=0x80, first=0, last=1.
REQ-040 blk_ready held 0 for 5 cycles while blk_valid=1 -> blk_data is constant, in_ready=0, and words offered in that window are not accepted.
REQ-041 rst pulsed after the head + 5 body words -> outputs are 0 asynchronously, no block is emitted, and a following fresh message is padded from byte 0.
REQ-042 body word offered in IDLE, then a second head during FILL -> proto_err=1 and stays 1 until rst; only the restarted message's block is emitted.
